// File: rtl/cw_pkg.sv
// Shared constants and state encoding for the constant-weight encoder/decoder pair.
package cw_pkg;
   localparam int N_W   = 12;
   localparam int T_W   = 5;
   localparam int D_W   = 11;
   localparam int U_W   = 4;
   localparam int T_MAX = 27;
   localparam int U_MAX = D_W - 1;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT_D, EMIT, BIN, DONE, ERR} state_e;
endpackage

// File: rtl/best_d.sv
// Picks the gap parameter d = 2^u from the remaining length n and weight t.
// u is the largest value in 1..U_MAX with t*2^(u+1) <= n, so d is roughly n/(2t).
import cw_pkg::*;

module best_d (
   input  logic           clk,
   input  logic [N_W-1:0] n,
   input  logic [T_W-1:0] t,
   output logic [D_W-1:0] d,
   output logic [U_W-1:0] u_minus_1
);
   localparam int X_W = N_W + D_W;

   logic [U_W-1:0] u;
   logic [X_W-1:0] nx;
   logic [X_W-1:0] tx;

   always_comb begin
      u  = U_W'(1);
      nx = X_W'(n);
      tx = '0;
      for (int k = 1; k <= U_MAX; k++) begin
         tx = X_W'(t) << (k + 1);
         if (tx <= nx) u = U_W'(k);
      end
   end

   always_ff @(posedge clk) begin
      d         <= D_W'(1) << u;
      u_minus_1 <= u - U_W'(1);
   end
endmodule

// File: rtl/cw_decoder.sv
// Constant-weight decoder: turns ascending support positions back into the serial
// bit string (unary '1' per full d, '0', then u-bit remainder MSB first) for each gap.
import cw_pkg::*;

module cw_decoder (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N_W-1:0] n_in,
   input  logic [T_W-1:0] t_in,
   input  logic           pos_valid,
   input  logic [N_W-1:0] pos,
   output logic           pos_ready,
   output logic           bit_valid,
   output logic           bit_out,
   input  logic           bit_ready,
   output logic           busy,
   output logic           done,
   output logic           err
);
   state_e         state;
   logic [N_W-1:0] n_r, n_tot, base, delta;
   logic [T_W-1:0] t_r;
   logic [U_W-1:0] cnt;
   logic [D_W-1:0] d;
   logic [U_W-1:0] u_minus_1;
   logic [N_W-1:0] d_ext, first_sh, next_sh;

   best_d u_best_d (
      .clk       (clk),
      .n         (n_r),
      .t         (t_r),
      .d         (d),
      .u_minus_1 (u_minus_1)
   );

   assign d_ext    = N_W'(d);
   assign first_sh = delta >> u_minus_1;
   assign next_sh  = delta >> (cnt - U_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pos_ready <= 1'b0;
         bit_valid <= 1'b0;
         bit_out   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         n_r       <= '0;
         n_tot     <= '0;
         t_r       <= '0;
         base      <= '0;
         delta     <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERR: if (start) begin
               n_r   <= n_in;
               n_tot <= n_in;
               t_r   <= t_in;
               base  <= '0;
               err   <= 1'b0;
               if (t_in == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  state     <= FETCH;
                  pos_ready <= 1'b1;
                  done      <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            FETCH: if (pos_valid) begin
               pos_ready <= 1'b0;
               if (pos < base || pos >= n_tot) begin
                  state <= ERR;
                  busy  <= 1'b0;
                  err   <= 1'b1;
               end else begin
                  delta <= pos - base;
                  base  <= pos + N_W'(1);
                  state <= WAIT_D;
               end
            end
            WAIT_D: state <= EMIT;
            // First EMIT cycle latches the decision once d reflects the updated n_r.
            EMIT: if (!bit_valid) begin
               bit_valid <= 1'b1;
               bit_out   <= (delta >= d_ext);
            end else if (bit_ready) begin
               if (bit_out) begin
                  delta     <= delta - d_ext;
                  n_r       <= n_r - d_ext;
                  bit_valid <= 1'b0;
                  bit_out   <= 1'b0;
                  state     <= WAIT_D;
               end else begin
                  cnt     <= u_minus_1;
                  bit_out <= first_sh[0];
                  state   <= BIN;
               end
            end
            BIN: if (bit_ready) begin
               if (cnt == '0) begin
                  bit_valid <= 1'b0;
                  bit_out   <= 1'b0;
                  n_r       <= n_r - delta - N_W'(1);
                  t_r       <= t_r - T_W'(1);
                  if (t_r == T_W'(1)) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state     <= FETCH;
                     pos_ready <= 1'b1;
                  end
               end else begin
                  cnt     <= cnt - U_W'(1);
                  bit_out <= next_sh[0];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
